// File: rtl/conv_loop_ctrl.sv
// conv_loop_ctrl: walks group/pixel/kernel/channel loops and emits one
// IFM/weight read tuple per cycle with padding, depthwise and backpressure.
module conv_loop_ctrl #(
   parameter int TOTAL_PE = 16,
   parameter int DIM_W    = 8,
   parameter int K_W      = 4,
   parameter int ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [K_W-1:0]    KERNEL_W,
   input  logic [DIM_W-1:0]  IFM_W,
   input  logic [DIM_W-1:0]  IFM_C,
   input  logic [DIM_W-1:0]  OFM_W,
   input  logic [DIM_W-1:0]  OFM_C,
   input  logic [1:0]        stride,
   input  logic [1:0]        pad,
   input  logic              mode,
   input  logic              cal_start,
   input  logic              stall,
   input  logic [ADDR_W-1:0] ifm_base_addr,
   input  logic [ADDR_W-1:0] wgt_base_addr,
   output logic              rd_valid,
   output logic [ADDR_W-1:0] ifm_addr,
   output logic [ADDR_W-1:0] wgt_addr,
   output logic              ifm_pad,
   output logic              acc_clear,
   output logic              acc_last,
   output logic [DIM_W-1:0]  oc_grp,
   output logic [DIM_W-1:0]  ofm_row,
   output logic [DIM_W-1:0]  ofm_col,
   output logic              busy,
   output logic              done
);
   localparam int IW = DIM_W + 3;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

   state_e state_q, state_d;

   logic [K_W-1:0]    k_q;
   logic [DIM_W-1:0]  ifm_w_q, ifm_c_q, ofm_w_q, ofm_c_q;
   logic [1:0]        s_q, pad_q;
   logic              mode_q;
   logic [ADDR_W-1:0] ifm_base_q, wgt_base_q;

   logic [DIM_W-1:0]  g_q, g_d, oh_q, oh_d, ow_q, ow_d, ic_q, ic_d;
   logic [K_W-1:0]    kh_q, kh_d, kw_q, kw_d;

   logic start, degen, accept;
   logic ic_last, kw_last, kh_last, ow_last, oh_last, g_last, all_last;
   logic [ADDR_W-1:0] grp_end;

   logic [IW-1:0]     ih, iw;
   logic              pad_hit;
   logic [ADDR_W-1:0] pix, kk;

   assign start  = (state_q == S_IDLE) && cal_start;
   assign degen  = (OFM_W == '0) || (OFM_C == '0) || (KERNEL_W == '0)
                || (!mode && (IFM_C == '0));
   assign accept = (state_q == S_RUN) && !stall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_q        <= '0;
         ifm_w_q    <= '0;
         ifm_c_q    <= '0;
         ofm_w_q    <= '0;
         ofm_c_q    <= '0;
         s_q        <= '0;
         pad_q      <= '0;
         mode_q     <= 1'b0;
         ifm_base_q <= '0;
         wgt_base_q <= '0;
      end else if (start) begin
         k_q        <= KERNEL_W;
         ifm_w_q    <= IFM_W;
         ifm_c_q    <= IFM_C;
         ofm_w_q    <= OFM_W;
         ofm_c_q    <= OFM_C;
         s_q        <= (stride == 2'd0) ? 2'd1 : stride;
         pad_q      <= pad;
         mode_q     <= mode;
         ifm_base_q <= ifm_base_addr;
         wgt_base_q <= wgt_base_addr;
      end
   end

   // Depthwise collapses the channel loop to a single iteration.
   assign ic_last  = mode_q || (ic_q == ifm_c_q - DIM_W'(1));
   assign kw_last  = (kw_q == k_q - K_W'(1));
   assign kh_last  = (kh_q == k_q - K_W'(1));
   assign ow_last  = (ow_q == ofm_w_q - DIM_W'(1));
   assign oh_last  = (oh_q == ofm_w_q - DIM_W'(1));
   assign grp_end  = (ADDR_W'(g_q) + ADDR_W'(1)) * ADDR_W'(TOTAL_PE);
   assign g_last   = (grp_end >= ADDR_W'(ofm_c_q));
   assign all_last = ic_last && kw_last && kh_last
                  && ow_last && oh_last && g_last;

   always_comb begin
      g_d  = g_q;
      oh_d = oh_q;
      ow_d = ow_q;
      kh_d = kh_q;
      kw_d = kw_q;
      ic_d = ic_q;
      if (state_q != S_RUN) begin
         g_d  = '0;
         oh_d = '0;
         ow_d = '0;
         kh_d = '0;
         kw_d = '0;
         ic_d = '0;
      end else if (accept) begin
         ic_d = ic_last ? '0 : ic_q + DIM_W'(1);
         if (ic_last) begin
            kw_d = kw_last ? '0 : kw_q + K_W'(1);
            if (kw_last) begin
               kh_d = kh_last ? '0 : kh_q + K_W'(1);
               if (kh_last) begin
                  ow_d = ow_last ? '0 : ow_q + DIM_W'(1);
                  if (ow_last) begin
                     oh_d = oh_last ? '0 : oh_q + DIM_W'(1);
                     if (oh_last) begin
                        g_d = g_last ? '0 : g_q + DIM_W'(1);
                     end
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         g_q     <= '0;
         oh_q    <= '0;
         ow_q    <= '0;
         kh_q    <= '0;
         kw_q    <= '0;
         ic_q    <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         oh_q    <= oh_d;
         ow_q    <= ow_d;
         kh_q    <= kh_d;
         kw_q    <= kw_d;
         ic_q    <= ic_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (cal_start) state_d = degen ? S_DONE : S_RUN;
         S_RUN:  if (accept && all_last) state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Negative indices wrap to large unsigned values and fail the bound too.
   always_comb begin
      ih = IW'(oh_q) * IW'(s_q) + IW'(kh_q) - IW'(pad_q);
      iw = IW'(ow_q) * IW'(s_q) + IW'(kw_q) - IW'(pad_q);
      pad_hit = ih[IW-1] || iw[IW-1]
             || (ih >= IW'(ifm_w_q)) || (iw >= IW'(ifm_w_q));
      pix = ADDR_W'(ih) * ADDR_W'(ifm_w_q) + ADDR_W'(iw);
      kk  = ADDR_W'(g_q) * ADDR_W'(k_q) * ADDR_W'(k_q)
          + ADDR_W'(kh_q) * ADDR_W'(k_q) + ADDR_W'(kw_q);

      rd_valid  = (state_q == S_RUN);
      busy      = rd_valid;
      done      = (state_q == S_DONE);
      ifm_addr  = '0;
      wgt_addr  = '0;
      ifm_pad   = 1'b0;
      acc_clear = 1'b0;
      acc_last  = 1'b0;
      oc_grp    = '0;
      ofm_row   = '0;
      ofm_col   = '0;
      if (rd_valid) begin
         ifm_pad = pad_hit;
         if (pad_hit) begin
            ifm_addr = ifm_base_q;
         end else if (mode_q) begin
            ifm_addr = ifm_base_q + pix * ADDR_W'(ifm_c_q)
                     + ADDR_W'(g_q) * ADDR_W'(TOTAL_PE);
         end else begin
            ifm_addr = ifm_base_q + pix * ADDR_W'(ifm_c_q)
                     + ADDR_W'(ic_q);
         end
         wgt_addr = mode_q ? wgt_base_q + kk
                  : wgt_base_q + kk * ADDR_W'(ifm_c_q) + ADDR_W'(ic_q);
         acc_clear = (kh_q == '0) && (kw_q == '0) && (ic_q == '0);
         acc_last  = kh_last && kw_last && ic_last;
         oc_grp    = g_q;
         ofm_row   = oh_q;
         ofm_col   = ow_q;
      end
   end

endmodule

// File: tb/tb_conv_loop_ctrl.sv
// tb_conv_loop_ctrl: directed checks of conv_loop_ctrl tuple streams,
// padding, depthwise, stride, stall hold, degenerate config and reset.
module tb_conv_loop_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  KERNEL_W;
   logic [7:0]  IFM_W, IFM_C, OFM_W, OFM_C;
   logic [1:0]  stride, pad;
   logic        mode, cal_start, stall;
   logic [31:0] ifm_base_addr, wgt_base_addr;
   logic        rd_valid, ifm_pad, acc_clear, acc_last, busy, done;
   logic [31:0] ifm_addr, wgt_addr;
   logic [7:0]  oc_grp, ofm_row, ofm_col;

   typedef struct packed {
      logic [31:0] ia;
      logic [31:0] wa;
      logic        pd;
      logic        cl;
      logic        ls;
      logic [7:0]  g;
      logic [7:0]  r;
      logic [7:0]  c;
   } tup_t;

   tup_t exp_q[$], obs[$], ref_q[$];
   int   errs = 0, checks = 0;
   int   nv, nc, ns, se;
   bit   gd, dn;

   conv_loop_ctrl dut (
      .clk(clk), .rst_n(rst_n), .KERNEL_W(KERNEL_W), .IFM_W(IFM_W),
      .IFM_C(IFM_C), .OFM_W(OFM_W), .OFM_C(OFM_C), .stride(stride),
      .pad(pad), .mode(mode), .cal_start(cal_start), .stall(stall),
      .ifm_base_addr(ifm_base_addr), .wgt_base_addr(wgt_base_addr),
      .rd_valid(rd_valid), .ifm_addr(ifm_addr), .wgt_addr(wgt_addr),
      .ifm_pad(ifm_pad), .acc_clear(acc_clear), .acc_last(acc_last),
      .oc_grp(oc_grp), .ofm_row(ofm_row), .ofm_col(ofm_col),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic tup_t cur();
      tup_t t;
      t.ia = ifm_addr;
      t.wa = wgt_addr;
      t.pd = ifm_pad;
      t.cl = acc_clear;
      t.ls = acc_last;
      t.g  = oc_grp;
      t.r  = ofm_row;
      t.c  = ofm_col;
      return t;
   endfunction

   task automatic set_std();
      KERNEL_W = 4'd3; IFM_W = 8'd4; IFM_C = 8'd2;
      OFM_W = 8'd2; OFM_C = 8'd16; stride = 2'd1; pad = 2'd0;
      mode = 1'b0; ifm_base_addr = 32'h100; wgt_base_addr = 32'h2000;
   endtask

   task automatic build_exp();
      int k, s, ng, nic, ih, iw;
      tup_t t;
      exp_q.delete();
      k   = int'(KERNEL_W);
      s   = (stride == 2'd0) ? 1 : int'(stride);
      ng  = (int'(OFM_C) + 15) / 16;
      nic = mode ? 1 : int'(IFM_C);
      for (int g = 0; g < ng; g++)
         for (int oh = 0; oh < int'(OFM_W); oh++)
            for (int ow = 0; ow < int'(OFM_W); ow++)
               for (int kh = 0; kh < k; kh++)
                  for (int kw = 0; kw < k; kw++)
                     for (int ic = 0; ic < nic; ic++) begin
                        ih = oh * s + kh - int'(pad);
                        iw = ow * s + kw - int'(pad);
                        t.pd = (ih < 0) || (iw < 0) ||
                               (ih >= int'(IFM_W)) || (iw >= int'(IFM_W));
                        t.ia = t.pd ? ifm_base_addr :
                               ifm_base_addr +
                               32'((ih * int'(IFM_W) + iw) * int'(IFM_C)
                                   + (mode ? g * 16 : ic));
                        t.wa = wgt_base_addr + 32'(mode ?
                               g * k * k + kh * k + kw :
                               (g * k * k + kh * k + kw) * int'(IFM_C) + ic);
                        t.cl = (kh == 0) && (kw == 0) && (ic == 0);
                        t.ls = (kh == k - 1) && (kw == k - 1) &&
                               (ic == nic - 1);
                        t.g  = 8'(g);
                        t.r  = 8'(oh);
                        t.c  = 8'(ow);
                        exp_q.push_back(t);
                     end
   endtask

   task automatic run(input string tag, input int stall_pct, input bit inject);
      obs.delete();
      nv = 0; nc = 0; ns = 0; se = 0; gd = 1'b0;
      cal_start = 1'b1;
      tick();
      cal_start = 1'b0;
      for (int c = 0; c < 20000 && !gd; c++) begin
         nc++;
         if (inject && c == 10) begin
            cal_start = 1'b1; IFM_C = 8'd7; OFM_W = 8'd3;
         end
         if (inject && c == 11) cal_start = 1'b0;
         if (done) begin
            gd = 1'b1;
            if (busy || rd_valid) se++;
         end else if (!rd_valid) begin
            se++;
         end else begin
            nv++;
            if (busy !== 1'b1) se++;
            if (obs.size() >= exp_q.size() || cur() !== exp_q[obs.size()])
               se++;
            stall = (stall_pct > 0) &&
                    (int'($urandom_range(0, 99)) < stall_pct);
            if (stall) ns++;
            else obs.push_back(cur());
         end
         if (!gd) tick();
      end
      stall = 1'b0;
      cal_start = 1'b0;
      check({tag, "_done_seen"}, gd, 1);
      check({tag, "_stream"}, se, 0);
      tick();
      dn = done;
      check({tag, "_done_pulse"}, dn, 0);
   endtask

   function automatic int diff_ref();
      int n = 0;
      if (obs.size() != ref_q.size()) return 9999;
      foreach (obs[i]) if (obs[i] !== ref_q[i]) n++;
      return n;
   endfunction

   function automatic int count_last();
      int n = 0;
      foreach (obs[i]) if (obs[i].ls) n++;
      return n;
   endfunction

   initial begin
      set_std();
      cal_start = 1'b0;
      stall = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_valid", rd_valid, 0);
      check("rst_busy_done", {busy, done}, 0);
      check("rst_addr", {ifm_addr, wgt_addr}, 0);
      check("rst_flags", {ifm_pad, acc_clear, acc_last}, 0);
      check("rst_coord", {oc_grp, ofm_row, ofm_col}, 0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // standard run
      set_std(); build_exp();
      run("std", 0, 1'b0);
      check("std_valid_cycles", nv, 72);
      check("std_cycles_to_done", nc, 73);
      check("std_ia0", obs[0].ia, 32'h100);
      check("std_ia1", obs[1].ia, 32'h101);
      check("std_ia2", obs[2].ia, 32'h102);
      check("std_ia_t7", obs[6].ia, 32'h108);
      check("std_first_clear", obs[0].cl, 1);
      check("std_last_pos", {obs[17].ls, obs[35].ls, obs[53].ls, obs[71].ls},
            4'hf);
      check("std_last_count", count_last(), 4);
      ref_q = obs;

      // random stall
      set_std(); build_exp();
      run("stall", 30, 1'b0);
      check("stall_some", ns > 0, 1);
      check("stall_same_seq", diff_ref(), 0);
      check("stall_valid_cycles", nv, 72 + ns);
      check("stall_cycles_to_done", nc, 73 + ns);

      // padding
      set_std(); IFM_W = 8'd4; OFM_W = 8'd4; IFM_C = 8'd1; pad = 2'd1;
      ifm_base_addr = 32'h400; build_exp();
      run("pad", 0, 1'b0);
      check("pad_valid_cycles", nv, 144);
      check("pad_t1", {obs[0].pd, obs[0].ia}, {1'b1, 32'h400});
      check("pad_t5", {obs[4].pd, obs[4].ia}, {1'b0, 32'h400});
      check("pad_p33_kh2", {obs[141].pd, obs[142].pd, obs[143].pd}, 3'b111);

      // depthwise
      set_std(); mode = 1'b1; OFM_C = 8'd32; IFM_W = 8'd3; OFM_W = 8'd1;
      IFM_C = 8'd32; ifm_base_addr = 32'h1000; wgt_base_addr = 32'h8000;
      build_exp();
      run("dw", 0, 1'b0);
      check("dw_valid_cycles", nv, 18);
      check("dw_t10_grp", obs[9].g, 1);
      check("dw_t10_ia", obs[9].ia, 32'h1010);
      check("dw_t10_wa", obs[9].wa, 32'h8009);

      // stride 2
      set_std(); stride = 2'd2; IFM_W = 8'd5; build_exp();
      run("s2", 0, 1'b0);
      check("s2_valid_cycles", nv, 72);
      check("s2_p11_coord", {obs[54].r, obs[54].c}, 16'h0101);
      check("s2_p11_ia", obs[54].ia, 32'h118);

      // stride 0 equals stride 1
      set_std(); stride = 2'd0; build_exp();
      run("s0", 0, 1'b0);
      check("s0_same_seq", diff_ref(), 0);

      // degenerate config
      set_std(); OFM_C = 8'd0; build_exp();
      run("degen", 0, 1'b0);
      check("degen_cycles", nc, 1);
      check("degen_valid", nv, 0);

      // start and config changes during RUN are ignored
      set_std(); build_exp();
      run("restart", 0, 1'b1);
      check("restart_same_seq", diff_ref(), 0);
      check("restart_valid_cycles", nv, 72);

      // reset mid-run
      set_std();
      cal_start = 1'b1;
      tick();
      cal_start = 1'b0;
      repeat (5) tick();
      check("mid_valid", rd_valid, 1);
      rst_n = 1'b0;
      #1;
      check("abort_valid_busy", {rd_valid, busy}, 0);
      check("abort_addr", {ifm_addr, wgt_addr}, 0);
      check("abort_flags", {ifm_pad, acc_clear, acc_last}, 0);
      check("abort_coord", {oc_grp, ofm_row, ofm_col}, 0);
      dn = 1'b0;
      repeat (3) begin
         tick();
         dn = dn | done;
      end
      rst_n = 1'b1;
      tick();
      dn = dn | done;
      check("abort_no_done", dn, 0);
      build_exp();
      run("fresh", 0, 1'b0);
      check("fresh_same_seq", diff_ref(), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
